// File: rtl/bus_pkg.sv
// ============================================================================
// Module  : bus_pkg
// Brief   : Shared IDs, header field offsets and FSM encoding for the bus arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bus_pkg;

    localparam int                ID_W     = 2;
    localparam logic [ID_W-1:0]   ID_CTRL  = 2'd3;
    localparam int                SRC_LSB  = 2;
    localparam int                DEST_LSB = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2,
        ACK   = 2'd3
    } state_t;

    function automatic logic [3:0] id_to_onehot(input logic [ID_W-1:0] id);
        return 4'b0001 << id;
    endfunction

    // Round-robin successor over the three data requesters (0 -> 1 -> 2 -> 0).
    function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] id);
        return (id >= 2'd2) ? 2'd0 : id + 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter3.sv
// ============================================================================
// Module  : rr_arbiter3
// Brief   : Combinational 3-way round-robin pick starting at the pointer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter3
    import bus_pkg::*;
(
    input  logic [2:0]      req,
    input  logic [ID_W-1:0] ptr,
    output logic [2:0]      pick,
    output logic            valid
);

    always_comb begin
        pick = 3'b000;
        case (ptr)
            2'd1: begin
                if      (req[1]) pick = 3'b010;
                else if (req[2]) pick = 3'b100;
                else if (req[0]) pick = 3'b001;
            end
            2'd2: begin
                if      (req[2]) pick = 3'b100;
                else if (req[0]) pick = 3'b001;
                else if (req[1]) pick = 3'b010;
            end
            default: begin
                if      (req[0]) pick = 3'b001;
                else if (req[1]) pick = 3'b010;
                else if (req[2]) pick = 3'b100;
            end
        endcase
    end

    assign valid = |req;

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ============================================================================
// Module  : bus_arbiter
// Brief   : Shared 8-bit bus arbiter/sequencer: grant, header check, beat count,
//           timeout abort and the 1-cycle ack that releases all data_bus users.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bus_arbiter
    import bus_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req,
    input  logic [4*LEN_W-1:0] req_len,
    input  logic               bus_valid,
    input  logic [7:0]         bus_data,
    output logic [3:0]         grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               busy,
    output logic               ack,
    output logic [1:0]         hdr_src,
    output logic [1:0]         hdr_dest,
    output logic               err_timeout,
    output logic               err_hdr
);

    localparam int               TO_W      = $clog2(TIMEOUT + 1);
    localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);
    localparam logic [TO_W-1:0]  c_timeout = TO_W'(TIMEOUT);

    state_t             r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_count;
    logic [TO_W-1:0]    r_tcnt;

    logic [LEN_W-1:0]   w_lens [4];
    logic [2:0]         w_rr_pick;
    logic               w_rr_valid;
    logic [ID_W-1:0]    w_rr_id;
    logic [ID_W-1:0]    w_win_id;
    logic               w_any_req;
    logic [LEN_W-1:0]   w_sel_len;
    logic [LEN_W-1:0]   w_len_clamped;
    logic [LEN_W-1:0]   w_count_next;
    logic [TO_W-1:0]    w_tcnt_next;
    logic               w_beat;
    logic               w_hdr_bad;
    logic               w_unused_data;

    generate
        for (genvar k = 0; k < 4; k++) begin : g_len
            assign w_lens[k] = req_len[k*LEN_W +: LEN_W];
        end
    endgenerate

    rr_arbiter3 u_rr (
        .req   (req[2:0]),
        .ptr   (r_ptr),
        .pick  (w_rr_pick),
        .valid (w_rr_valid)
    );

    always_comb begin
        w_rr_id = 2'd0;
        if (w_rr_pick[1]) w_rr_id = 2'd1;
        if (w_rr_pick[2]) w_rr_id = 2'd2;
    end

    assign w_any_req     = req[3] | w_rr_valid;
    assign w_win_id      = req[3] ? ID_CTRL : w_rr_id;
    assign w_sel_len     = w_lens[w_win_id];
    assign w_len_clamped = ((w_sel_len == '0) || (w_sel_len > c_max_len)) ? c_max_len : w_sel_len;
    assign w_count_next  = r_count + LEN_W'(1);
    assign w_tcnt_next   = r_tcnt + TO_W'(1);
    assign w_beat        = (bus_valid == 1'b1);
    // The control requester may address on behalf of others, so its src is not checked.
    assign w_hdr_bad     = (grant_id != ID_CTRL) && (bus_data[SRC_LSB +: ID_W] != grant_id);
    assign w_unused_data = &{1'b0, bus_data[7:6], bus_data[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_len       <= '0;
            r_count     <= '0;
            r_tcnt      <= '0;
            grant       <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            ack         <= 1'b0;
            hdr_src     <= '0;
            hdr_dest    <= '0;
            err_timeout <= 1'b0;
            err_hdr     <= 1'b0;
        end else begin
            ack         <= 1'b0;
            err_timeout <= 1'b0;
            err_hdr     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        grant    <= id_to_onehot(w_win_id);
                        grant_id <= w_win_id;
                        busy     <= 1'b1;
                        r_len    <= w_len_clamped;
                        r_count  <= '0;
                        r_tcnt   <= '0;
                        r_state  <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_beat) begin
                        hdr_src  <= bus_data[SRC_LSB  +: ID_W];
                        hdr_dest <= bus_data[DEST_LSB +: ID_W];
                        r_count  <= LEN_W'(1);
                        r_tcnt   <= '0;
                        if (w_hdr_bad) begin
                            err_hdr <= 1'b1;
                            ack     <= 1'b1;
                            r_state <= ACK;
                        end else if (r_len == LEN_W'(1)) begin
                            ack     <= 1'b1;
                            r_state <= ACK;
                        end else begin
                            r_state <= XFER;
                        end
                    end else if (!req[grant_id]) begin
                        ack     <= 1'b1;
                        r_state <= ACK;
                    end else if (w_tcnt_next == c_timeout) begin
                        err_timeout <= 1'b1;
                        ack         <= 1'b1;
                        r_state     <= ACK;
                    end else begin
                        r_tcnt <= w_tcnt_next;
                    end
                end
                XFER: begin
                    // A beat on the timeout cycle still completes normally.
                    if (w_beat) begin
                        r_count <= w_count_next;
                        r_tcnt  <= '0;
                        if (w_count_next == r_len) begin
                            ack     <= 1'b1;
                            r_state <= ACK;
                        end
                    end else if (w_tcnt_next == c_timeout) begin
                        err_timeout <= 1'b1;
                        ack         <= 1'b1;
                        r_state     <= ACK;
                    end else begin
                        r_tcnt <= w_tcnt_next;
                    end
                end
                ACK: begin
                    grant    <= '0;
                    grant_id <= '0;
                    busy     <= 1'b0;
                    if (grant_id != ID_CTRL) begin
                        r_ptr <= rr_next(grant_id);
                    end
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// Module  : tb_bus_arbiter
// Brief   : Directed self-checking bench for bus_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;
    localparam int TIMEOUT = 64;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [3:0]         req;
    logic [4*LEN_W-1:0] req_len;
    logic               bus_valid;
    logic [7:0]         bus_data;
    logic [3:0]         grant;
    logic [1:0]         grant_id;
    logic               busy;
    logic               ack;
    logic [1:0]         hdr_src;
    logic [1:0]         hdr_dest;
    logic               err_timeout;
    logic               err_hdr;

    int checks   = 0;
    int failures = 0;

    bus_arbiter #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_len     (req_len),
        .bus_valid   (bus_valid),
        .bus_data    (bus_data),
        .grant       (grant),
        .grant_id    (grant_id),
        .busy        (busy),
        .ack         (ack),
        .hdr_src     (hdr_src),
        .hdr_dest    (hdr_dest),
        .err_timeout (err_timeout),
        .err_hdr     (err_hdr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input logic [1:0] id);
        int n;
        n = 0;
        while (!busy && n < 20) begin
            step();
            n++;
        end
        check("grant_wait", 32'(n < 20), 32'd1);
        check("grant", 32'(grant), 32'(4'b0001 << id));
        check("grant_id", 32'(grant_id), 32'(id));
    endtask

    // Header carries src=dest=id; ack must appear only after the last beat.
    task automatic run_txn(input logic [1:0] id, input int nbeats);
        logic early;
        early = 1'b0;
        wait_grant(id);
        for (int b = 0; b < nbeats; b++) begin
            bus_valid = 1'b1;
            bus_data  = (b == 0) ? {2'b00, id, id, 2'b00} : 8'(8'hA9 + b);
            step();
            if (b < nbeats - 1 && ack) early = 1'b1;
        end
        bus_valid = 1'b0;
        check("ack_early", 32'(early), 32'd0);
        check("ack", 32'(ack), 32'd1);
        check("err_hdr_clean", 32'(err_hdr), 32'd0);
        check("err_to_clean", 32'(err_timeout), 32'd0);
    endtask

    task automatic post_ack();
        step();
        check("post_busy", 32'(busy), 32'd0);
        check("post_ack", 32'(ack), 32'd0);
        check("post_grant", 32'(grant), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic early;
        rst_n     = 1'b0;
        req       = '0;
        req_len   = '0;
        bus_valid = 1'b0;
        bus_data  = '0;
        step();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_errs", 32'({err_hdr, err_timeout}), 32'd0);
        rst_n = 1'b1;
        step();

        // Single transfer: ID 1, len 3, header 8'h14
        req     = 4'b0010;
        req_len = {5'd0, 5'd0, 5'd3, 5'd0};
        step();
        check("t1_grant_lat", 32'(grant), 32'h2);
        run_txn(2'd1, 3);
        check("t1_hdr_src", 32'(hdr_src), 32'd1);
        check("t1_hdr_dest", 32'(hdr_dest), 32'd1);
        req = '0;
        post_ack();

        // Priority then round-robin from a fresh pointer
        req     = 4'b1111;
        req_len = {5'd1, 5'd1, 5'd1, 5'd1};
        do_reset();
        run_txn(2'd3, 1);
        post_ack();
        run_txn(2'd3, 1);
        req = 4'b0111;
        post_ack();
        run_txn(2'd0, 1);
        post_ack();
        run_txn(2'd1, 1);
        post_ack();
        run_txn(2'd2, 1);
        post_ack();
        run_txn(2'd0, 1);
        req = '0;
        post_ack();

        // Header src mismatch on ID 2
        req     = 4'b0100;
        req_len = {5'd0, 5'd4, 5'd0, 5'd0};
        wait_grant(2'd2);
        bus_valid = 1'b1;
        bus_data  = 8'h04;
        step();
        bus_valid = 1'b0;
        req       = '0;
        check("hdr_err", 32'(err_hdr), 32'd1);
        check("hdr_ack", 32'(ack), 32'd1);
        post_ack();

        // Length clamp: 0 and 31 both become 16 beats
        req     = 4'b0010;
        req_len = {5'd0, 5'd0, 5'd0, 5'd0};
        run_txn(2'd1, 16);
        req = '0;
        post_ack();
        req     = 4'b0100;
        req_len = {5'd0, 5'd31, 5'd0, 5'd0};
        run_txn(2'd2, 16);
        req = '0;
        post_ack();

        // Request dropped before the header: silent ack
        req     = 4'b0001;
        req_len = {5'd0, 5'd0, 5'd0, 5'd4};
        wait_grant(2'd0);
        req = '0;
        step();
        check("drop_ack", 32'(ack), 32'd1);
        check("drop_errs", 32'({err_hdr, err_timeout}), 32'd0);
        post_ack();

        // Final beat on the would-be timeout cycle wins
        req     = 4'b0010;
        req_len = {5'd0, 5'd0, 5'd2, 5'd0};
        wait_grant(2'd1);
        bus_valid = 1'b1;
        bus_data  = 8'h14;
        step();
        bus_valid = 1'b0;
        early = 1'b0;
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            step();
            if (ack) early = 1'b1;
        end
        check("race_no_early", 32'(early), 32'd0);
        bus_valid = 1'b1;
        bus_data  = 8'h55;
        step();
        bus_valid = 1'b0;
        check("race_ack", 32'(ack), 32'd1);
        check("race_no_to", 32'(err_timeout), 32'd0);
        req = '0;
        post_ack();

        // Timeout: ID 0, len 4, one beat then silence
        req     = 4'b0001;
        req_len = {5'd0, 5'd0, 5'd0, 5'd4};
        wait_grant(2'd0);
        bus_valid = 1'b1;
        bus_data  = 8'h00;
        step();
        bus_valid = 1'b0;
        early = 1'b0;
        for (int i = 1; i <= TIMEOUT; i++) begin
            step();
            if (i < TIMEOUT && ack) early = 1'b1;
        end
        check("to_no_early", 32'(early), 32'd0);
        check("to_ack", 32'(ack), 32'd1);
        check("to_err", 32'(err_timeout), 32'd1);
        req = '0;
        post_ack();

        // Reset mid-transfer: RR pointer returns to ID 0
        req     = 4'b0010;
        req_len = {5'd0, 5'd0, 5'd4, 5'd0};
        wait_grant(2'd1);
        bus_valid = 1'b1;
        bus_data  = 8'h14;
        step();
        bus_data = 8'h22;
        rst_n    = 1'b0;
        #1;
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ack", 32'(ack), 32'd0);
        bus_valid = 1'b0;
        req       = 4'b0011;
        step();
        rst_n = 1'b1;
        step();
        check("rst_rr_grant", 32'(grant), 32'h1);
        check("rst_rr_id", 32'(grant_id), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
